// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the parametrised two-pattern sequence detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_detector_pkg;

  // Fill state of the symbol window, derived from the fill counter.
  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_FILLING = 2'd1,
    FILL_ARMED   = 2'd2
  } fill_state_e;

  // Widest symbol and pattern the helper function can handle.
  localparam int SYM_MAX = 32;
  localparam int PAT_MAX = 64;

  // Default patterns for W=2, L=3; the first symbol sits in the MSBs.
  localparam logic [5:0] DEF_PAT_A = 6'b00_01_10;
  localparam logic [5:0] DEF_PAT_B = 6'b11_01_10;

  // Extract symbol idx (0 = first, oldest symbol) of an l-symbol pattern of w-bit symbols.
  function automatic logic [SYM_MAX-1:0] pat_sym(
    input logic [PAT_MAX-1:0] pattern,
    input int                 idx,
    input int                 w,
    input int                 l
  );
    logic [PAT_MAX-1:0] shifted;
    logic [SYM_MAX-1:0] mask;
    shifted = pattern >> ((l - 1 - idx) * w);
    mask    = (SYM_MAX'(1) << w) - SYM_MAX'(1);
    return SYM_MAX'(shifted) & mask;
  endfunction

endpackage

// File: rtl/seq_window.sv
// Shift register of the last L-1 accepted symbols plus a saturating fill counter.
// Latency: window and fill update on the edge that samples shift/flush/clr.
// Backpressure: none; accepts one symbol per cycle whenever shift is high.
module seq_window
  import seq_detector_pkg::*;
#(
  parameter int W = 2,
  parameter int L = 3
) (
  input  logic               clock,
  input  logic               reset_,
  input  logic               clr,
  input  logic               shift,
  input  logic               flush,
  input  logic [W-1:0]       din,
  output logic [(L-1)*W-1:0] window,
  output fill_state_e        fill_state,
  output logic               armed
);

  localparam int FW = (L > 2) ? $clog2(L) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(L - 1);

  logic [FW-1:0]        fill;
  logic [(L-1)*W-1:0]   next_window;

  // The oldest symbol falls off the top when a new one is shifted in.
  if (L == 2) begin : g_single
    assign next_window = din;
  end else begin : g_multi
    assign next_window = {window[(L-2)*W-1:0], din};
  end

  // Classify the fill counter into EMPTY / FILLING / ARMED.
  always_comb begin
    fill_state = FILL_FILLING;
    if (fill == '0) begin
      fill_state = FILL_EMPTY;
    end else if (fill == FILL_MAX) begin
      fill_state = FILL_ARMED;
    end
  end

  assign armed = (fill_state == FILL_ARMED);

  // Window and fill counter: clear beats flush beats shift.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      fill   <= '0;
      window <= '0;
    end else if (clr) begin
      fill   <= '0;
      window <= '0;
    end else if (flush) begin
      fill   <= '0;
    end else if (shift) begin
      window <= next_window;
      if (!armed) begin
        fill <= fill + FW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Counts occurrences of pattern A/B in a valid-qualified W-bit symbol stream.
// Latency: match and z update on the edge that samples the final symbol.
// Backpressure: none; one symbol accepted on every cycle valid is high.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int               W     = 2,
  parameter int               L     = 3,
  parameter int               N     = 4,
  parameter logic [L*W-1:0]   PAT_A = (L*W)'(DEF_PAT_A),
  parameter logic [L*W-1:0]   PAT_B = (L*W)'(DEF_PAT_B),
  parameter bit               SAT   = 1'b0
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         clr,
  input  logic         valid,
  input  logic [W-1:0] x1_x0,
  input  logic         mode_alt,
  input  logic         overlap,
  output logic [N-1:0] z,
  output logic         match,
  output logic         expect_b
);

  logic [(L-1)*W-1:0] window;
  fill_state_e        fill_state;
  logic               armed;
  logic [L*W-1:0]     cand;
  logic               eq_a;
  logic               eq_b;
  logic               target_hit;
  logic               hit;
  logic               win_shift;
  logic               win_flush;

  // The candidate is the stored history followed by the symbol on the input now.
  assign cand = {window, x1_x0};

  // Symbol-by-symbol compare of the candidate against both patterns.
  always_comb begin
    eq_a = 1'b1;
    eq_b = 1'b1;
    for (int i = 0; i < L; i++) begin
      if (SYM_MAX'(cand[(L-1-i)*W +: W]) != pat_sym(PAT_MAX'(PAT_A), i, W, L)) begin
        eq_a = 1'b0;
      end
      if (SYM_MAX'(cand[(L-1-i)*W +: W]) != pat_sym(PAT_MAX'(PAT_B), i, W, L)) begin
        eq_b = 1'b0;
      end
    end
  end

  // Alternate mode looks only for the pattern selected by the count parity.
  always_comb begin
    target_hit = eq_a | eq_b;
    if (mode_alt) begin
      target_hit = z[0] ? eq_b : eq_a;
    end
  end

  assign hit       = valid && armed && target_hit;
  assign win_flush = hit && !overlap;
  assign win_shift = valid && !win_flush;

  seq_window #(
    .W (W),
    .L (L)
  ) u_window (
    .clock      (clock),
    .reset_     (reset_),
    .clr        (clr),
    .shift      (win_shift),
    .flush      (win_flush),
    .din        (x1_x0),
    .window     (window),
    .fill_state (fill_state),
    .armed      (armed)
  );

  // Hit counter and one-cycle match pulse; clr overrides a simultaneous hit.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      z     <= '0;
      match <= 1'b0;
    end else if (clr) begin
      z     <= '0;
      match <= 1'b0;
    end else if (hit) begin
      match <= 1'b1;
      if (!(SAT && (z == {N{1'b1}}))) begin
        z <= z + N'(1);
      end
    end else begin
      match <= 1'b0;
    end
  end

  // Parity of the registered count decides which pattern is expected next.
  assign expect_b = z[0];

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic clock;
  logic reset_;

  // Default-parameter instance
  logic       d_clr, d_valid, d_alt, d_ovl;
  logic [1:0] d_x;
  logic [3:0] d_z;
  logic       d_match, d_eb;

  // W=1, pattern 101 instance
  logic       b_clr, b_valid, b_alt, b_ovl;
  logic [0:0] b_x;
  logic [3:0] b_z;
  logic       b_match, b_eb;

  // N=2 instances sharing stimulus: saturating and wrapping
  logic       n_clr, n_valid, n_alt, n_ovl;
  logic [1:0] n_x;
  logic [1:0] s_z, w_z;
  logic       s_match, s_eb, w_match, w_eb;

  int compared;
  int mismatched;

  seq_detector_param u_def (
    .clock(clock), .reset_(reset_), .clr(d_clr), .valid(d_valid), .x1_x0(d_x),
    .mode_alt(d_alt), .overlap(d_ovl), .z(d_z), .match(d_match), .expect_b(d_eb)
  );

  seq_detector_param #(.W(1), .L(3), .N(4), .PAT_A(3'b101), .PAT_B(3'b101), .SAT(1'b0)) u_bit (
    .clock(clock), .reset_(reset_), .clr(b_clr), .valid(b_valid), .x1_x0(b_x),
    .mode_alt(b_alt), .overlap(b_ovl), .z(b_z), .match(b_match), .expect_b(b_eb)
  );

  seq_detector_param #(.N(2), .SAT(1'b1)) u_sat (
    .clock(clock), .reset_(reset_), .clr(n_clr), .valid(n_valid), .x1_x0(n_x),
    .mode_alt(n_alt), .overlap(n_ovl), .z(s_z), .match(s_match), .expect_b(s_eb)
  );

  seq_detector_param #(.N(2), .SAT(1'b0)) u_wrap (
    .clock(clock), .reset_(reset_), .clr(n_clr), .valid(n_valid), .x1_x0(n_x),
    .mode_alt(n_alt), .overlap(n_ovl), .z(w_z), .match(w_match), .expect_b(w_eb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive on the falling edge, return 1 time unit after the next rising edge.
  task automatic d_step(input logic c, input logic v, input logic [1:0] s);
    @(negedge clock);
    d_clr = c; d_valid = v; d_x = s;
    @(posedge clock);
    #1;
  endtask

  task automatic b_step(input logic c, input logic v, input logic s);
    @(negedge clock);
    b_clr = c; b_valid = v; b_x = s;
    @(posedge clock);
    #1;
  endtask

  task automatic n_step(input logic c, input logic v, input logic [1:0] s);
    @(negedge clock);
    n_clr = c; n_valid = v; n_x = s;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clock);
    @(posedge clock);
    #1;
    compared += 6;
    if (d_z !== 4'd0)    begin mismatched++; $display("FAIL reset_d_z: got %0d want 0", d_z); end
    if (d_match !== 1'b0) begin mismatched++; $display("FAIL reset_d_match: got %b want 0", d_match); end
    if (d_eb !== 1'b0)   begin mismatched++; $display("FAIL reset_d_expect_b: got %b want 0", d_eb); end
    if (b_z !== 4'd0)    begin mismatched++; $display("FAIL reset_b_z: got %0d want 0", b_z); end
    if (s_z !== 2'd0)    begin mismatched++; $display("FAIL reset_s_z: got %0d want 0", s_z); end
    if (w_z !== 2'd0)    begin mismatched++; $display("FAIL reset_w_z: got %0d want 0", w_z); end
    @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic test_alt_mode;
    logic [1:0] seq [9];
    logic       exp_m [9];
    logic [3:0] exp_z [9];
    seq   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    exp_m = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_z = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    d_alt = 1'b1; d_ovl = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d_step(1'b0, 1'b1, seq[i]);
      compared += 2;
      if (d_match !== exp_m[i]) begin mismatched++; $display("FAIL alt_match[%0d]: got %b want %b", i, d_match, exp_m[i]); end
      if (d_z !== exp_z[i])     begin mismatched++; $display("FAIL alt_z[%0d]: got %0d want %0d", i, d_z, exp_z[i]); end
      if (i == 2) begin
        compared++;
        if (d_eb !== 1'b1) begin mismatched++; $display("FAIL alt_expect_b: got %b want 1", d_eb); end
      end
    end
    d_step(1'b0, 1'b0, 2'd0);
    compared++;
    if (d_match !== 1'b0) begin mismatched++; $display("FAIL alt_pulse_end: got %b want 0", d_match); end
  endtask

  task automatic test_any_mode;
    logic [1:0] seq [6];
    logic       exp_m [6];
    int         pulses;
    seq   = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    exp_m = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pulses = 0;
    d_step(1'b1, 1'b0, 2'd0);
    compared++;
    if (d_z !== 4'd0) begin mismatched++; $display("FAIL any_clr_z: got %0d want 0", d_z); end
    d_alt = 1'b0; d_ovl = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d_step(1'b0, 1'b1, seq[i]);
      if (d_match === 1'b1) pulses++;
      compared++;
      if (d_match !== exp_m[i]) begin mismatched++; $display("FAIL any_match[%0d]: got %b want %b", i, d_match, exp_m[i]); end
    end
    compared += 2;
    if (pulses != 2)  begin mismatched++; $display("FAIL any_pulses: got %0d want 2", pulses); end
    if (d_z !== 4'd2) begin mismatched++; $display("FAIL any_z: got %0d want 2", d_z); end
    d_step(1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_overlap;
    logic seq [5];
    logic exp_on [5];
    logic exp_off [5];
    seq     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_on  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_off = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    b_alt = 1'b0; b_ovl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_step(1'b0, 1'b1, seq[i]);
      compared++;
      if (b_match !== exp_on[i]) begin mismatched++; $display("FAIL ovl_on_match[%0d]: got %b want %b", i, b_match, exp_on[i]); end
    end
    compared++;
    if (b_z !== 4'd2) begin mismatched++; $display("FAIL ovl_on_z: got %0d want 2", b_z); end
    b_step(1'b1, 1'b0, 1'b0);
    b_ovl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_step(1'b0, 1'b1, seq[i]);
      compared++;
      if (b_match !== exp_off[i]) begin mismatched++; $display("FAIL ovl_off_match[%0d]: got %b want %b", i, b_match, exp_off[i]); end
    end
    compared++;
    if (b_z !== 4'd1) begin mismatched++; $display("FAIL ovl_off_z: got %0d want 1", b_z); end
    b_step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation;
    logic [1:0] exp_s [6];
    logic [1:0] exp_w [6];
    exp_s = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    n_alt = 1'b0; n_ovl = 1'b0;
    for (int h = 0; h < 6; h++) begin
      n_step(1'b0, 1'b1, 2'd0);
      n_step(1'b0, 1'b1, 2'd1);
      n_step(1'b0, 1'b1, 2'd2);
      compared += 4;
      if (s_z !== exp_s[h])  begin mismatched++; $display("FAIL sat_z[%0d]: got %0d want %0d", h, s_z, exp_s[h]); end
      if (s_match !== 1'b1)  begin mismatched++; $display("FAIL sat_match[%0d]: got %b want 1", h, s_match); end
      if (w_z !== exp_w[h])  begin mismatched++; $display("FAIL wrap_z[%0d]: got %0d want %0d", h, w_z, exp_w[h]); end
      if (w_match !== 1'b1)  begin mismatched++; $display("FAIL wrap_match[%0d]: got %b want 1", h, w_match); end
    end
    n_step(1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_async_reset;
    d_step(1'b1, 1'b0, 2'd0);
    d_alt = 1'b1; d_ovl = 1'b0;
    d_step(1'b0, 1'b1, 2'd0);
    d_step(1'b0, 1'b1, 2'd1);
    d_step(1'b0, 1'b1, 2'd2);
    compared++;
    if (d_z !== 4'd1) begin mismatched++; $display("FAIL areset_pre_z: got %0d want 1", d_z); end
    d_step(1'b0, 1'b1, 2'd0);
    d_step(1'b0, 1'b1, 2'd1);
    #3;
    d_valid = 1'b0;
    reset_ = 1'b0;
    #1;
    compared += 3;
    if (d_z !== 4'd0)     begin mismatched++; $display("FAIL areset_z: got %0d want 0", d_z); end
    if (d_match !== 1'b0) begin mismatched++; $display("FAIL areset_match: got %b want 0", d_match); end
    if (d_eb !== 1'b0)    begin mismatched++; $display("FAIL areset_expect_b: got %b want 0", d_eb); end
    #1;
    reset_ = 1'b1;
    d_step(1'b0, 1'b1, 2'd2);
    compared++;
    if (d_match !== 1'b0) begin mismatched++; $display("FAIL areset_lone_match: got %b want 0", d_match); end
    d_step(1'b0, 1'b1, 2'd0);
    d_step(1'b0, 1'b1, 2'd1);
    d_step(1'b0, 1'b1, 2'd2);
    compared += 2;
    if (d_match !== 1'b1) begin mismatched++; $display("FAIL areset_post_match: got %b want 1", d_match); end
    if (d_z !== 4'd1)     begin mismatched++; $display("FAIL areset_post_z: got %0d want 1", d_z); end
    d_step(1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_valid_gaps;
    logic       vv [7];
    logic [1:0] ss [7];
    logic       exp_m [7];
    int         pulses;
    vv    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ss    = '{2'd0, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd2};
    exp_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pulses = 0;
    d_step(1'b1, 1'b0, 2'd0);
    d_alt = 1'b1; d_ovl = 1'b0;
    for (int i = 0; i < 7; i++) begin
      d_step(1'b0, vv[i], ss[i]);
      if (d_match === 1'b1) pulses++;
      compared++;
      if (d_match !== exp_m[i]) begin mismatched++; $display("FAIL gap_match[%0d]: got %b want %b", i, d_match, exp_m[i]); end
    end
    compared += 2;
    if (pulses != 1)  begin mismatched++; $display("FAIL gap_pulses: got %0d want 1", pulses); end
    if (d_z !== 4'd1) begin mismatched++; $display("FAIL gap_z: got %0d want 1", d_z); end
    d_alt = 1'b0;
    d_step(1'b0, 1'b1, 2'd0);
    d_step(1'b0, 1'b1, 2'd1);
    d_step(1'b1, 1'b1, 2'd2);
    compared += 2;
    if (d_z !== 4'd0)     begin mismatched++; $display("FAIL clr_hit_z: got %0d want 0", d_z); end
    if (d_match !== 1'b0) begin mismatched++; $display("FAIL clr_hit_match: got %b want 0", d_match); end
    d_step(1'b0, 1'b0, 2'd0);
    compared++;
    if (d_match !== 1'b0) begin mismatched++; $display("FAIL clr_hit_after: got %b want 0", d_match); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset_ = 1'b0;
    d_clr = 1'b0; d_valid = 1'b0; d_x = 2'd0; d_alt = 1'b0; d_ovl = 1'b0;
    b_clr = 1'b0; b_valid = 1'b0; b_x = 1'b0; b_alt = 1'b0; b_ovl = 1'b0;
    n_clr = 1'b0; n_valid = 1'b0; n_x = 2'd0; n_alt = 1'b0; n_ovl = 1'b0;
    test_reset();
    test_alt_mode();
    test_any_mode();
    test_overlap();
    test_saturation();
    test_async_reset();
    test_valid_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: run did not complete, compared %0d", compared);
    $fatal(1, "timeout");
  end

endmodule
